// File: rtl/dc_sequencer.sv
// rtl/dc_sequencer.sv - control sequencer for the digital-controller datapath
// Runs EEPROM configuration loads and the per-conversion PID update with a Booth multiply.
module dc_sequencer #(
  parameter int MULT_ITERS = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ld_cfg,
  input  logic       dis,
  input  logic [1:0] c_prod,
  output logic [2:0] c_asel,
  output logic [2:0] c_bsel,
  output logic       c_err,
  output logic       c_duty,
  output logic       c_sumerr,
  output logic       c_xset,
  output logic       c_preverr,
  output logic       c_pid,
  output logic       c_init_prod,
  output logic       c_subtract,
  output logic       c_multsat,
  output logic       c_clr_duty,
  output logic       c_eep_reg,
  output logic [1:0] eep_addr,
  output logic       busy,
  output logic       done
);

  localparam int CW = (MULT_ITERS > 1) ? $clog2(MULT_ITERS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(MULT_ITERS - 1);

  localparam logic [2:0] ASEL_XMEAS    = 3'b001;
  localparam logic [2:0] ASEL_ERR      = 3'b010;
  localparam logic [2:0] ASEL_PROD2815 = 3'b011;
  localparam logic [2:0] ASEL_ZEROA    = 3'b111;

  localparam logic [2:0] BSEL_XSET     = 3'b000;
  localparam logic [2:0] BSEL_SUMERRB  = 3'b001;
  localparam logic [2:0] BSEL_ZEROB    = 3'b011;
  localparam logic [2:0] BSEL_PID      = 3'b100;
  localparam logic [2:0] BSEL_PROD2512 = 3'b110;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LDX_A,
    S_LDX_W,
    S_LDP_A,
    S_LDP_W,
    S_ERR,
    S_SUM,
    S_MINIT,
    S_MULT,
    S_DUTY,
    S_PREV
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] iter_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      eep_addr <= 2'd0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_MINIT) begin
        iter_cnt <= '0;
      end else if (state == S_MULT) begin
        iter_cnt <= iter_cnt + CW'(1);
      end
      // Address is presented one cycle ahead of the write state that consumes the data.
      if (state_nx == S_LDX_A) begin
        eep_addr <= 2'd0;
      end else if (state_nx == S_LDP_A) begin
        eep_addr <= 2'd1;
      end
      done <= (state == S_LDP_W) || (state == S_PREV);
    end
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nx    = state;
    c_asel      = ASEL_ZEROA;
    c_bsel      = BSEL_ZEROB;
    c_err       = 1'b0;
    c_duty      = 1'b0;
    c_sumerr    = 1'b0;
    c_xset      = 1'b0;
    c_preverr   = 1'b0;
    c_pid       = 1'b0;
    c_init_prod = 1'b0;
    c_subtract  = 1'b0;
    c_multsat   = 1'b0;
    c_clr_duty  = 1'b0;
    c_eep_reg   = 1'b0;

    case (state)
      S_IDLE: begin
        c_clr_duty = dis;
        if (ld_cfg) begin
          state_nx = S_LDX_A;
        end else if (start && !dis) begin
          state_nx = S_ERR;
        end
      end
      S_LDX_A: state_nx = S_LDX_W;
      S_LDX_W: begin
        c_eep_reg = 1'b1;
        c_xset    = 1'b1;
        state_nx  = S_LDP_A;
      end
      S_LDP_A: state_nx = S_LDP_W;
      S_LDP_W: begin
        c_eep_reg = 1'b1;
        c_pid     = 1'b1;
        state_nx  = S_IDLE;
      end
      S_ERR: begin
        c_asel     = ASEL_XMEAS;
        c_bsel     = BSEL_XSET;
        c_subtract = 1'b1;
        c_err      = 1'b1;
        state_nx   = S_SUM;
      end
      S_SUM: begin
        c_asel   = ASEL_ERR;
        c_bsel   = BSEL_SUMERRB;
        c_sumerr = 1'b1;
        state_nx = S_MINIT;
      end
      S_MINIT: begin
        c_asel      = ASEL_ZEROA;
        c_bsel      = BSEL_SUMERRB;
        c_init_prod = 1'b1;
        state_nx    = S_MULT;
      end
      S_MULT: begin
        // Booth radix-2 recode: 01 adds the gain, 10 subtracts it, 00/11 only shift.
        c_asel = ASEL_PROD2815;
        case (c_prod)
          2'b01: c_bsel = BSEL_PID;
          2'b10: begin
            c_bsel     = BSEL_PID;
            c_subtract = 1'b1;
          end
          default: c_bsel = BSEL_ZEROB;
        endcase
        if (iter_cnt == LAST_ITER) begin
          state_nx = S_DUTY;
        end
      end
      S_DUTY: begin
        c_asel    = ASEL_ZEROA;
        c_bsel    = BSEL_PROD2512;
        c_multsat = 1'b1;
        c_duty    = 1'b1;
        state_nx  = S_PREV;
      end
      S_PREV: begin
        c_asel    = ASEL_ERR;
        c_bsel    = BSEL_ZEROB;
        c_preverr = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dc_sequencer.sv
// tb/tb_dc_sequencer.sv - scoreboard bench for dc_sequencer
// Stimulus queues expected per-cycle control vectors; the monitor compares on busy/done cycles.
module tb_dc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ld_cfg = 1'b0;
  logic       dis = 1'b0;
  logic [1:0] c_prod = 2'b00;
  logic [2:0] c_asel;
  logic [2:0] c_bsel;
  logic       c_err, c_duty, c_sumerr, c_xset, c_preverr, c_pid;
  logic       c_init_prod, c_subtract, c_multsat, c_clr_duty, c_eep_reg;
  logic [1:0] eep_addr;
  logic       busy;
  logic       done;

  dc_sequencer #(.MULT_ITERS(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ld_cfg(ld_cfg), .dis(dis), .c_prod(c_prod),
    .c_asel(c_asel), .c_bsel(c_bsel), .c_err(c_err), .c_duty(c_duty), .c_sumerr(c_sumerr),
    .c_xset(c_xset), .c_preverr(c_preverr), .c_pid(c_pid), .c_init_prod(c_init_prod),
    .c_subtract(c_subtract), .c_multsat(c_multsat), .c_clr_duty(c_clr_duty),
    .c_eep_reg(c_eep_reg), .eep_addr(eep_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Flag order: err duty sumerr xset preverr pid init_prod subtract multsat clr_duty eep_reg
  localparam logic [10:0] F_ERR  = 11'h400;
  localparam logic [10:0] F_DUTY = 11'h200;
  localparam logic [10:0] F_SUM  = 11'h100;
  localparam logic [10:0] F_XSET = 11'h080;
  localparam logic [10:0] F_PREV = 11'h040;
  localparam logic [10:0] F_PID  = 11'h020;
  localparam logic [10:0] F_INIT = 11'h010;
  localparam logic [10:0] F_SUB  = 11'h008;
  localparam logic [10:0] F_MSAT = 11'h004;
  localparam logic [10:0] F_CLR  = 11'h002;
  localparam logic [10:0] F_EEP  = 11'h001;

  typedef struct {
    logic [18:0] vec;
    logic        chk_addr;
    logic [1:0]  addr;
    logic [47:0] nm;
  } rec_t;

  rec_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        idle_chk = 1'b0;
  logic [18:0] idle_exp = '0;
  logic        idle_addr_chk = 1'b0;
  logic        fin_chk = 1'b0;
  logic [1:0]  pat[4] = '{2'b01, 2'b10, 2'b00, 2'b11};

  function automatic logic [18:0] mk(input logic b, input logic d, input logic [2:0] a,
                                     input logic [2:0] bs, input logic [10:0] f);
    return {b, d, a, bs, f};
  endfunction

  task automatic push(input logic [18:0] v, input logic ca, input logic [1:0] ad, input logic [47:0] nm);
    rec_t r;
    r.vec = v; r.chk_addr = ca; r.addr = ad; r.nm = nm;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    logic [18:0] act;
    rec_t r;
    act = {busy, done, c_asel, c_bsel, c_err, c_duty, c_sumerr, c_xset, c_preverr, c_pid,
           c_init_prod, c_subtract, c_multsat, c_clr_duty, c_eep_reg};
    if (busy || done) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_cycle t=%0t actual=%h required=none", $time, act);
      end else begin
        r = exp_q.pop_front();
        if (act !== r.vec || (r.chk_addr && eep_addr !== r.addr)) begin
          n_err++;
          $display("FAIL %s t=%0t actual=%h/addr%0d required=%h/addr%0d",
                   r.nm, $time, act, eep_addr, r.vec, r.addr);
        end
      end
    end else if (idle_chk) begin
      n_vec++;
      if (act !== idle_exp || (idle_addr_chk && eep_addr !== 2'd0)) begin
        n_err++;
        $display("FAIL idle t=%0t actual=%h/addr%0d required=%h", $time, act, eep_addr, idle_exp);
      end
    end
    if (fin_chk) begin
      n_vec++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL missing_cycles actual=%0d required=0", exp_q.size());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cfg(input logic with_start, input logic clr_done);
    push(mk(1, 0, 3'b111, 3'b011, 11'h0), 1, 2'd0, "LDX_A");
    push(mk(1, 0, 3'b111, 3'b011, F_XSET | F_EEP), 1, 2'd0, "LDX_W");
    push(mk(1, 0, 3'b111, 3'b011, 11'h0), 1, 2'd1, "LDP_A");
    push(mk(1, 0, 3'b111, 3'b011, F_PID | F_EEP), 1, 2'd1, "LDP_W");
    push(mk(0, 1, 3'b111, 3'b011, clr_done ? F_CLR : 11'h0), 1, 2'd1, "CDONE");
    ld_cfg = 1'b1;
    start  = with_start;
    next_cycle();
    ld_cfg = 1'b0;
    start  = 1'b0;
    repeat (5) next_cycle();
  endtask

  // dis_at: cycle that raises dis; extra_at: cycle with a stray start; rst_at: cycle that resets.
  task automatic run_pid(input int dis_at, input int extra_at, input int rst_at);
    int last;
    logic [1:0] p;
    last = (rst_at != 0) ? rst_at - 1 : 20;
    for (int k = 1; k <= last; k++) begin
      p = (k >= 4 && k <= 17) ? pat[(k - 4) % 4] : 2'b00;
      if (k == 1)       push(mk(1, 0, 3'b001, 3'b000, F_ERR | F_SUB), 0, 2'd0, "ERR");
      else if (k == 2)  push(mk(1, 0, 3'b010, 3'b001, F_SUM), 0, 2'd0, "SUM");
      else if (k == 3)  push(mk(1, 0, 3'b111, 3'b001, F_INIT), 0, 2'd0, "MINIT");
      else if (k <= 17) begin
        if (p == 2'b01)      push(mk(1, 0, 3'b011, 3'b100, 11'h0), 0, 2'd0, "MULT01");
        else if (p == 2'b10) push(mk(1, 0, 3'b011, 3'b100, F_SUB), 0, 2'd0, "MULT10");
        else                 push(mk(1, 0, 3'b011, 3'b011, 11'h0), 0, 2'd0, "MULTSH");
      end
      else if (k == 18) push(mk(1, 0, 3'b111, 3'b110, F_MSAT | F_DUTY), 0, 2'd0, "DUTY");
      else if (k == 19) push(mk(1, 0, 3'b010, 3'b011, F_PREV), 0, 2'd0, "PREV");
      else              push(mk(0, 1, 3'b111, 3'b011, (dis_at != 0) ? F_CLR : 11'h0), 0, 2'd0, "PDONE");
    end
    start = 1'b1;
    next_cycle();
    for (int k = 1; k <= last; k++) begin
      c_prod = (k >= 4 && k <= 17) ? pat[(k - 4) % 4] : 2'b00;
      if (k == dis_at) dis = 1'b1;
      start = (k == extra_at);
      next_cycle();
    end
    start  = 1'b0;
    c_prod = 2'b00;
  endtask

  initial begin
    // Reset state
    idle_exp      = mk(0, 0, 3'b111, 3'b011, 11'h0);
    idle_addr_chk = 1'b1;
    idle_chk      = 1'b1;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    repeat (2) next_cycle();
    idle_chk      = 1'b0;
    idle_addr_chk = 1'b0;

    run_cfg(1'b0, 1'b0);
    run_pid(0, 0, 0);
    run_pid(0, 10, 0);
    run_cfg(1'b1, 1'b0);

    // Disabled in IDLE: duty held clear, start ignored
    dis      = 1'b1;
    idle_exp = mk(0, 0, 3'b111, 3'b011, F_CLR);
    idle_chk = 1'b1;
    start    = 1'b1;
    next_cycle();
    start    = 1'b0;
    repeat (3) next_cycle();
    idle_chk = 1'b0;
    dis      = 1'b0;
    next_cycle();

    // Disable raised mid-update; update completes and clears duty from the done cycle
    run_pid(5, 0, 0);
    idle_exp = mk(0, 0, 3'b111, 3'b011, F_CLR);
    idle_chk = 1'b1;
    next_cycle();
    idle_chk = 1'b0;

    // Config load still honoured while disabled
    run_cfg(1'b0, 1'b1);
    dis = 1'b0;
    next_cycle();

    // Asynchronous reset in the middle of MULT
    run_pid(0, 0, 8);
    rst_n         = 1'b0;
    idle_exp      = mk(0, 0, 3'b111, 3'b011, 11'h0);
    idle_addr_chk = 1'b1;
    idle_chk      = 1'b1;
    next_cycle();
    rst_n = 1'b1;
    repeat (4) next_cycle();
    idle_chk      = 1'b0;
    idle_addr_chk = 1'b0;

    fin_chk = 1'b1;
    @(negedge clk);
    #1;
    fin_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
